seq_mult_engine: RTL and testbench
==================================

Name: seq_mult_engine

Overview:
Iterative unsigned shift-add multiplier. It is the engine-side responder to a controller that drives eng_start and waits on eng_done. The controller pulses or holds eng_start. The engine drops eng_done for exactly WIDTH cycles while it computes, then raises eng_done with the product valid. It sits beside the controller and is clocked by the same clk/rst.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; must be >= 2.
CW, 4, iteration counter width; must satisfy 2**CW >= WIDTH.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
eng_start  input  1  request from controller; level-sampled, with re-arm rule below
a_in  input  WIDTH  multiplicand, sampled only on the accepting edge
b_in  input  WIDTH  multiplier, sampled only on the accepting edge
eng_done  output  1  1 = idle/result valid; 0 = computing
product  output  2*WIDTH  last completed result, registered

Behaviour:
- Reset (rst=1 at an edge) clears all state:
  - state=IDLE, eng_done=1, product=0, counter=0, accumulator=0, armed=1.
  - Reset has priority over every other event, including mid-operation; an in-flight multiply is abandoned and no partial result is written to product.
- States:
  - IDLE: eng_done=1.
  - BUSY: eng_done=0.
  - eng_done is a direct decode of state and is glitch-free (registered state).
- armed flag:
  - Set whenever eng_start is sampled 0 in IDLE; also set at reset.
  - Cleared when an operation is accepted.
  - Purpose: a start held high across completion must not trigger a second operation.
- Accept:
  - At an edge with state=IDLE, armed=1, eng_start=1: latch mcand={WIDTH'b0,a_in}, mplier=b_in, acc=0, counter=0, armed=0; next state BUSY.
  - eng_done reads 0 in the cycle following that edge.
- BUSY, each edge:
  - if mplier[0]=1 then acc <= acc + mcand (2*WIDTH-bit add, no overflow possible).
  - mcand <= mcand<<1; mplier <= mplier>>1; counter <= counter+1.
  - When counter == WIDTH-1 at an edge: product <= final acc value including this cycle's add; state <= IDLE.
- Latency:
  - Accept at edge k gives eng_done=0 from edge k through edge k+WIDTH.
  - eng_done=1 and product valid after edge k+WIDTH, i.e. exactly WIDTH cycles low.
- eng_start is ignored during BUSY (any level, any toggling).
- Held start:
  - If eng_start is still 1 when returning to IDLE, no new operation starts; armed stays 0.
  - eng_start must be seen 0 for at least one IDLE cycle before the next accept.
- a_in/b_in changes during BUSY have no effect.
- product holds its value until the next completion; it never changes while BUSY.
- Back-to-back:
  - Earliest re-accept is 2 edges after completion: one IDLE edge with start=0 to re-arm, then one with start=1.
- Arithmetic is unsigned. Zero operands still take the full WIDTH cycles; there is no early termination.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, start=0 -> eng_done=1, product=0x0000 throughout.
2. Basic multiply: a=13, b=11, start high 1 cycle -> eng_done low exactly 8 cycles, then high with product=143 (0x008F).
3. Extremes: a=255, b=255 -> product=65025 (0xFE01). Then a=0, b=200 -> product=0, still 8 busy cycles.
4. Held start and input churn:
   - start held high 2 cycles, then left high 20 cycles; a=6, b=7 -> exactly one operation, product=42, eng_done stays 1 after completion while start remains high.
   - Toggling a_in/b_in during BUSY does not alter 42.
   - Dropping start then raising it with a=3, b=5 -> new operation, product=15.
5. Reset mid-operation: accept a=100, b=100, assert rst at busy cycle 4 -> next cycle eng_done=1, product=0. Then start with a=2, b=3 works normally -> product=6.
6. Controller handshake loop: connect to the start/done controller, issue 3 requests -> each request yields exactly one busy window of 8 cycles and the correct product; no extra eng_done falling edges.

Source files
------------

// File: rtl/seq_mult_engine.sv
// seq_mult_engine: iterative unsigned shift-add multiplier answering a start/done handshake
module seq_mult_engine #(
  parameter int WIDTH = 8,
  parameter int CW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               eng_start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               eng_done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic armed;
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0] counter;
  always_comb acc_nxt = mplier[0] ? acc + mcand : acc;
  assign eng_done = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      armed   <= 1'b1;
      product <= '0;
      counter <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (state == IDLE) begin
      if (!eng_start) armed <= 1'b1;
      else if (armed) begin
        mcand   <= {{WIDTH{1'b0}}, a_in};
        mplier  <= b_in;
        acc     <= '0;
        counter <= '0;
        armed   <= 1'b0;
        state   <= BUSY;
      end
    end else begin
      acc     <= acc_nxt;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      counter <= counter + CW'(1);
      if (counter == CW'(WIDTH - 1)) begin
        product <= acc_nxt;
        state   <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_mult_engine.sv
// tb_seq_mult_engine: table, random and corner-sequence checks of the shift-add multiplier
module tb_seq_mult_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eng_start = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic eng_done;
  logic [15:0] product;
  int total = 0;
  int bad = 0;
  int falls = 0;
  logic prev_done = 1'b1;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  vec_t vecs[8];
  seq_mult_engine #(.WIDTH(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .eng_start(eng_start), .a_in(a_in), .b_in(b_in),
    .eng_done(eng_done), .product(product)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (prev_done && !eng_done) falls++;
    prev_done = eng_done;
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    a_in = a;
    b_in = b;
    eng_start = 1'b1;
    tick();
    eng_start = 1'b0;
    chk("accept_done_low", {31'b0, eng_done}, 0);
  endtask
  task automatic wait_done(input string name, input logic [15:0] exp, input logic [15:0] old);
    int busy = 0;
    logic held = 1'b1;
    while (!eng_done && busy < 50) begin
      busy++;
      if (product !== old) held = 1'b0;
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      tick();
    end
    chk({name, "_busy_cycles"}, busy, 8);
    chk({name, "_product_held"}, {31'b0, held}, 1);
    chk({name, "_product"}, {16'b0, product}, {16'b0, exp});
  endtask
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    logic [15:0] old = product;
    accept(a, b);
    wait_done(name, exp, old);
    tick();
  endtask
  initial begin
    int f0;
    logic [15:0] old;
    vecs[0] = '{8'd13, 8'd11, 16'd143};
    vecs[1] = '{8'd255, 8'd255, 16'd65025};
    vecs[2] = '{8'd0, 8'd200, 16'd0};
    vecs[3] = '{8'd1, 8'd1, 16'd1};
    vecs[4] = '{8'd255, 8'd1, 16'd255};
    vecs[5] = '{8'd1, 8'd255, 16'd255};
    vecs[6] = '{8'd128, 8'd2, 16'd256};
    vecs[7] = '{8'd200, 8'd0, 16'd0};
    tick();
    tick();
    chk("reset_done", {31'b0, eng_done}, 1);
    chk("reset_product", {16'b0, product}, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_done", {31'b0, eng_done}, 1);
    chk("idle_product", {16'b0, product}, 0);
    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
    f0 = falls;
    old = product;
    a_in = 8'd6;
    b_in = 8'd7;
    eng_start = 1'b1;
    tick();
    chk("held_accept", {31'b0, eng_done}, 0);
    for (int i = 0; i < 21; i++) begin
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      tick();
    end
    chk("held_done_high", {31'b0, eng_done}, 1);
    chk("held_product", {16'b0, product}, 42);
    chk("held_single_op", falls - f0, 1);
    eng_start = 1'b0;
    tick();
    run_op("rearm", 8'd3, 8'd5, 16'd15);
    accept(8'd100, 8'd100);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_done", {31'b0, eng_done}, 1);
    chk("midrst_product", {16'b0, product}, 0);
    tick();
    chk("midrst_stays_idle", {31'b0, eng_done}, 1);
    run_op("after_rst", 8'd2, 8'd3, 16'd6);
    f0 = falls;
    for (int i = 0; i < 3; i++) run_op($sformatf("ctrl%0d", i), 8'(7 * i + 9), 8'(31 * i + 4), 16'((7 * i + 9) * (31 * i + 4)));
    chk("ctrl_falls", falls - f0, 3);
    f0 = falls;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] a = 8'($urandom);
      logic [7:0] b = 8'($urandom);
      run_op($sformatf("rnd%0d", i), a, b, 16'(int'(a) * int'(b)));
    end
    chk("rnd_falls", falls - f0, 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
